// File: rtl/little_window_detector.sv
`default_nettype none
// ============================================================================
//  Module      : little_window_detector
//  Description : Pixel-clock sink that measures active frame size and the
//                bounding box of non-background pixels, compares the box to
//                expected coefficients and reports one result set per frame.
//                Optional CRC output enabled by LITTLE_WINDOW_CRC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module little_window_detector #(
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter int          CW       = 12,
    parameter int          AW       = 16
) (
    input  logic          pclk,
    input  logic          prst,
    input  logic          enable,
    input  logic          vsync,
    input  logic          hsync,
    input  logic          de,
    input  logic [23:0]   data,
    input  logic [CW-1:0] exp_top,
    input  logic [CW-1:0] exp_left,
    input  logic [CW-1:0] exp_width,
    input  logic [CW-1:0] exp_height,
    output logic [AW-1:0] hactive,
    output logic [AW-1:0] vactive,
    output logic [CW-1:0] win_top,
    output logic [CW-1:0] win_left,
    output logic [CW-1:0] win_width,
    output logic [CW-1:0] win_height,
    output logic          win_found,
    output logic          line_err,
`ifdef LITTLE_WINDOW_CRC_EN
    output logic [15:0]   win_crc,
`endif
    output logic          match,
    output logic          meas_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_q, vsync_p_q, de_q, de_p_q;
    logic [23:0]     data_q;
    logic [AW-1:0]   x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, hlen_ref_q, hlen_ref_d;
    logic            hlen_set_q, hlen_set_d, err_q, err_d, found_q, found_d;
    logic [CW-1:0]   min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
    logic [AW-1:0]   hactive_q, hactive_d, vactive_q, vactive_d;
    logic [CW-1:0]   win_top_q, win_top_d, win_left_q, win_left_d;
    logic [CW-1:0]   win_width_q, win_width_d, win_height_q, win_height_d;
    logic            win_found_q, win_found_d, line_err_q, line_err_d;
    logic            match_q, match_d, meas_valid_q, meas_valid_d;
`ifdef LITTLE_WINDOW_CRC_EN
    logic [15:0]     crc_acc_q, crc_acc_d, win_crc_q, win_crc_d;
`endif

    logic            w_vs_rise, w_de_rise, w_de_fall, w_active, w_frame_end;
    logic [AW-1:0]   x_pos;
    logic [CW-1:0]   px_x, px_y;
    logic            w_unused;

    assign w_unused = hsync;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Clamp a line/pixel count into the coordinate range.
    function automatic logic [CW-1:0] to_coord(input logic [AW-1:0] v);
        return ((v >> CW) != '0) ? {CW{1'b1}} : v[CW-1:0];
    endfunction

`ifdef LITTLE_WINDOW_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    assign w_vs_rise   = vsync_q & ~vsync_p_q;
    assign w_de_rise   = de_q & ~de_p_q;
    assign w_de_fall   = ~de_q & de_p_q;
    assign w_active    = enable && (state_q != IDLE);
    assign w_frame_end = w_active && (state_q == MEAS) && w_vs_rise;

    always_comb begin
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        hlen_ref_d   = hlen_ref_q;
        hlen_set_d   = hlen_set_q;
        err_d        = err_q;
        found_d      = found_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;
        hactive_d    = hactive_q;
        vactive_d    = vactive_q;
        win_top_d    = win_top_q;
        win_left_d   = win_left_q;
        win_width_d  = win_width_q;
        win_height_d = win_height_q;
        win_found_d  = win_found_q;
        line_err_d   = line_err_q;
        match_d      = match_q;
        meas_valid_d = 1'b0;
`ifdef LITTLE_WINDOW_CRC_EN
        crc_acc_d    = crc_acc_q;
        win_crc_d    = win_crc_q;
`endif
        x_pos        = '0;
        px_x         = '0;
        px_y         = '0;

        case (state_q)
            IDLE:    if (enable) state_d = SYNC;
            SYNC:    if (w_vs_rise) state_d = MEAS;
            MEAS:    state_d = MEAS;
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;

        if (!w_active) begin
            x_cnt_d    = '0;
            y_cnt_d    = '0;
            hlen_ref_d = '0;
            hlen_set_d = 1'b0;
            err_d      = 1'b0;
            found_d    = 1'b0;
            min_x_d    = '0;
            max_x_d    = '0;
            min_y_d    = '0;
            max_y_d    = '0;
`ifdef LITTLE_WINDOW_CRC_EN
            crc_acc_d  = 16'hFFFF;
`endif
        end else begin
            // A line ending on the vsync-rise cycle still belongs to the closing frame.
            if (w_de_fall) begin
                y_cnt_d = sat_inc(y_cnt_q);
                if (!hlen_set_q) begin
                    hlen_ref_d = x_cnt_q;
                    hlen_set_d = 1'b1;
                end else if (x_cnt_q != hlen_ref_q) begin
                    err_d = 1'b1;
                end
            end

            if (w_frame_end) begin
                hactive_d   = hlen_ref_d;
                vactive_d   = y_cnt_d;
                win_found_d = found_q;
                line_err_d  = err_d;
                if (found_q) begin
                    win_left_d   = min_x_q;
                    win_top_d    = min_y_q;
                    win_width_d  = max_x_q - min_x_q + 1'b1;
                    win_height_d = max_y_q - min_y_q + 1'b1;
                end else begin
                    win_left_d   = '0;
                    win_top_d    = '0;
                    win_width_d  = '0;
                    win_height_d = '0;
                end
                match_d = found_q && (win_top_d == exp_top) && (win_left_d == exp_left) &&
                          (win_width_d == exp_width) && (win_height_d == exp_height);
                meas_valid_d = 1'b1;
`ifdef LITTLE_WINDOW_CRC_EN
                win_crc_d = crc_acc_q;
`endif
            end

            if (w_vs_rise) begin
                y_cnt_d    = '0;
                hlen_ref_d = '0;
                hlen_set_d = 1'b0;
                err_d      = 1'b0;
                found_d    = 1'b0;
`ifdef LITTLE_WINDOW_CRC_EN
                crc_acc_d  = 16'hFFFF;
`endif
            end

            // A pixel on the vsync-rise cycle is the first of the new frame.
            if (de_q) begin
                x_pos   = w_de_rise ? '0 : x_cnt_q;
                x_cnt_d = sat_inc(x_pos);
                px_x    = to_coord(x_pos);
                px_y    = to_coord(y_cnt_d);
`ifdef LITTLE_WINDOW_CRC_EN
                crc_acc_d = crc_step(crc_acc_d, data_q);
`endif
                if (data_q != BG_COLOR) begin
                    if (!found_d) begin
                        min_x_d = px_x;
                        max_x_d = px_x;
                        min_y_d = px_y;
                        max_y_d = px_y;
                        found_d = 1'b1;
                    end else begin
                        if (px_x < min_x_d) min_x_d = px_x;
                        if (px_x > max_x_d) max_x_d = px_x;
                        if (px_y < min_y_d) min_y_d = px_y;
                        if (px_y > max_y_d) max_y_d = px_y;
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            vsync_p_q    <= 1'b0;
            de_q         <= 1'b0;
            de_p_q       <= 1'b0;
            data_q       <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            hlen_ref_q   <= '0;
            hlen_set_q   <= 1'b0;
            err_q        <= 1'b0;
            found_q      <= 1'b0;
            min_x_q      <= '0;
            max_x_q      <= '0;
            min_y_q      <= '0;
            max_y_q      <= '0;
            hactive_q    <= '0;
            vactive_q    <= '0;
            win_top_q    <= '0;
            win_left_q   <= '0;
            win_width_q  <= '0;
            win_height_q <= '0;
            win_found_q  <= 1'b0;
            line_err_q   <= 1'b0;
            match_q      <= 1'b0;
            meas_valid_q <= 1'b0;
`ifdef LITTLE_WINDOW_CRC_EN
            crc_acc_q    <= '0;
            win_crc_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            vsync_p_q    <= vsync_q;
            de_q         <= de;
            de_p_q       <= de_q;
            data_q       <= data;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            hlen_ref_q   <= hlen_ref_d;
            hlen_set_q   <= hlen_set_d;
            err_q        <= err_d;
            found_q      <= found_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
            hactive_q    <= hactive_d;
            vactive_q    <= vactive_d;
            win_top_q    <= win_top_d;
            win_left_q   <= win_left_d;
            win_width_q  <= win_width_d;
            win_height_q <= win_height_d;
            win_found_q  <= win_found_d;
            line_err_q   <= line_err_d;
            match_q      <= match_d;
            meas_valid_q <= meas_valid_d;
`ifdef LITTLE_WINDOW_CRC_EN
            crc_acc_q    <= crc_acc_d;
            win_crc_q    <= win_crc_d;
`endif
        end
    end

    assign hactive    = hactive_q;
    assign vactive    = vactive_q;
    assign win_top    = win_top_q;
    assign win_left   = win_left_q;
    assign win_width  = win_width_q;
    assign win_height = win_height_q;
    assign win_found  = win_found_q;
    assign line_err   = line_err_q;
    assign match      = match_q;
    assign meas_valid = meas_valid_q;
`ifdef LITTLE_WINDOW_CRC_EN
    assign win_crc    = win_crc_q;
`endif

endmodule
`default_nettype wire

// File: doc/little_window_detector.md
Name: little_window_detector

Overview:
- Receiver/checker for the native video stream that the little-window pattern source drives (vsync, hsync, de, 24-bit data).
- Measures active frame size and the bounding box of non-background pixels on every frame.
- Compares the box against expected window coefficients and reports one result set per frame.
- Sits on the sink side of the clipper/VDMA path, in the pixel clock domain; used for self-check in synthesis builds and for loopback verification.

Parameters:
- BG_COLOR, 24'h000000, pixel value treated as background (outside window)
- CW, 12, coordinate/size width of window coefficients and results
- AW, 16, width of measured hactive/vactive

Ports:
- pclk  input  1  pixel clock
- prst  input  1  synchronous active-high reset
- enable  input  1  measurement enable
- vsync  input  1  frame sync, active high; frame starts on rising edge
- hsync  input  1  line sync, active high (informational; lines counted on de)
- de  input  1  data enable
- data  input  24  pixel data
- exp_top  input  CW  expected window top
- exp_left  input  CW  expected window left
- exp_width  input  CW  expected window width
- exp_height  input  CW  expected window height
- hactive  output  AW  measured pixels per active line (first line of frame)
- vactive  output  AW  measured active lines per frame
- win_top  output  CW  measured window top row
- win_left  output  CW  measured window left column
- win_width  output  CW  measured window width
- win_height  output  CW  measured window height
- win_found  output  1  at least one non-background pixel in frame
- line_err  output  1  some line's de length differed from the first line's
- match  output  1  win_found and all four measured values equal expected
- meas_valid  output  1  one-cycle pulse when result outputs update

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0.
- Input sampling: vsync, de and data are registered once. Edge detection uses the registered versus the previous registered sample.
- FSM states: IDLE, SYNC, MEAS.
  - IDLE -> SYNC when enable=1.
  - SYNC waits for a vsync rising edge -> MEAS. The first, partial frame is discarded.
  - In MEAS, each vsync rising edge ends the current frame and begins the next.
  - enable=0 in any state -> IDLE at the next cycle, with no meas_valid. Outputs hold their last values.
- Counters:
  - x_cnt clears on a de rising edge and increments per de pixel.
  - y_cnt increments on each de falling edge and clears on vsync rise.
- First line of the frame: at its de fall, hlen_ref = x_cnt. On every later de fall, x_cnt != hlen_ref sets a frame-local line_err flag.
- Bounding box: a pixel with de=1 and data != BG_COLOR updates min_x, max_x, min_y, max_y. The first such pixel in a frame initialises all four and sets found.
- Frame end (vsync rise while in MEAS):
  - Register outputs: hactive=hlen_ref, vactive=y_cnt, win_found=found, line_err.
  - If found: win_left=min_x, win_top=min_y, win_width=max_x-min_x+1, win_height=max_y-min_y+1. Otherwise all four are 0.
  - match=found and (win_top,win_left,win_width,win_height)==(exp_top,exp_left,exp_width,exp_height).
  - meas_valid=1 for exactly one cycle, 2 cycles after the vsync rise at the port (1 input register + 1 output register).
  - Frame-local state clears in the same cycle.
- Widths and saturation:
  - Coordinate counters saturate at 2^CW-1. Line/pixel counters saturate at 2^AW-1. There is no wrap.
  - Width and height computations are CW bits.
- Simultaneous events:
  - de fall and vsync rise in the same cycle: the line is counted first, then the frame closes.
  - de=1 on the vsync rise cycle: that pixel belongs to the new frame.
- Frame with no de: hactive=0, vactive=0, win_found=0, match=0, meas_valid still pulses.
- Reset mid-frame: everything returns to reset values immediately at the next pclk edge. The partial frame is never reported.

Optional Feature:
- Macro: LITTLE_WINDOW_CRC_EN.
- When defined:
  - Adds output win_crc [15:0], the CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the 24-bit data of every de pixel, MSB-first, in raster order.
  - win_crc latches at frame end with meas_valid and resets to 0.
- When undefined: no port and no logic.

Test Plan:
- 1920x1080 frames, BG 0, window 24'hFF0000 at top=100 left=200 width=64 height=32, exp_* equal to it -> second frame: hactive=1920, vactive=1080, win_top=100, win_left=200, win_width=64, win_height=32, win_found=1, match=1, line_err=0, one meas_valid pulse.
- Same stream with exp_left=201 -> match=0, other results unchanged.
- All-background frames -> win_found=0, all win_* 0, match=0, meas_valid pulses per frame.
- Line 5 shortened to 1919 pixels -> line_err=1 for that frame only; next clean frame line_err=0.
- Assert prst mid-frame, release -> outputs 0, no meas_valid until a full frame after the next vsync rise; enable low mid-frame -> no pulse.
- (LITTLE_WINDOW_CRC_EN) 4x2 frame of pixels 0x000001..0x000008 -> win_crc equals the software model's CRC-16-CCITT over those 24 bytes.
